pipe_mem_wb_ext: RTL and testbench
==================================

Name: pipe_mem_wb_ext

Overview:
- Parametrised MEM/WB pipeline register for the five-stage core, between the data-memory access stage (s4) and register-file writeback (s5).
- Adds to the plain s4→s5 flop bank:
  - configurable register depth
  - per-entry valid bit
  - stall/hold and flush/bubble control
  - byte-lane load alignment with sign/zero extension and a malformed-enable flag
  - writeback data select
  - sticky halt that freezes the pipe

Parameters:
- BITS, 32, data word width; multiple of 8, ≥16.
- REG_WORDS, 32, register-file depth.
- ADDR_LEFT, $clog2(REG_WORDS)-1, MSB index of register address.
- STAGES, 1, number of register stages s4→s5 (1..4); sets latency.
- BE_W, BITS/8, byte-enable width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hold all stages.
- flush  in  1  capture a bubble into stage 1 instead of s4 inputs.
- valid_s4  in  1  s4 holds a real instruction.
- alu_out_s4  in  BITS  ALU result / memory address.
- atomic_s4  in  1  atomic op flag.
- link_rw_s4  in  1  link-register write, active-low.
- d_mem_rdata  in  BITS  raw data-memory read word.
- sel_mem_s4  in  1  1 = writeback from memory, 0 = from ALU.
- rw_s4  in  1  register write, active-low.
- waddr_s4  in  ADDR_LEFT+1  destination register.
- byte_en_s4  in  BE_W  load byte lanes.
- load_signed_s4  in  1  1 = sign-extend sub-word load.
- halt_s4  in  1  halt instruction.
- valid_s5  out  1  final-stage entry valid.
- alu_out_s5  out  BITS
- atomic_s5  out  1
- sel_mem_s5  out  1
- d_mem_rdata_s5  out  BITS  raw read word.
- load_data_s5  out  BITS  aligned, extended load data.
- wb_data_s5  out  BITS  sel_mem_s5 ? load_data_s5 : alu_out_s5 (combinational from regs).
- link_rw_s5  out  1
- rw_s5  out  1
- waddr_s5  out  ADDR_LEFT+1
- byte_en_s5  out  BE_W
- lane_err_s5  out  1  byte_en pattern was illegal for a memory load.
- halt_s5  out  1  sticky halt.

Behaviour:
- **Reset** (rst=1, asynchronous, every stage):
  - valid=0, halt=0, lane_err=0, atomic=0, sel_mem=0
  - rw=1, link_rw=1
  - byte_en=all ones
  - all data/address fields=0
  - wb_data_s5 therefore 0.
- **Latency:** exactly STAGES clocks from s4 to s5 when not stalled. Stage i+1 captures stage i each unstalled edge.
- **Stall (stall=1):** every stage holds; inputs ignored.
- **Freeze:** halt_s5=1 behaves as permanent stall until rst.
- **Bubble insertion:** flush=1 with stall=0, or valid_s4=0, loads a bubble into stage 1:
  - valid=0, rw=1, link_rw=1, atomic=0, sel_mem=0, halt=0, lane_err=0
  - byte_en=all ones, data/address fields=0
  - A bubble never writes the register file.
- **Stall and flush together:** stall wins and the flush is dropped. Upstream holds flush until stall drops.
- **Halt:** halt_s5 sets when an entry with valid=1, halt=1 reaches the final stage, and stays 1 until reset. That entry's writeback fields are still presented. Later entries never reach s5.
- **Load alignment:** computed when stage 1 captures; lane k = bits 8k+7:8k.
  - One-hot byte_en (lane k): lane k→bits 7:0; upper bits = lane k bit 7 if load_signed else 0.
  - Aligned lane pair (lanes 2j, 2j+1 only): →bits 15:0; extended from bit 15 per load_signed.
  - All ones: word passed unchanged.
  - Any other pattern, including all zero, with sel_mem_s4=1 and valid: load_data=raw word, lane_err=1.
  - lane_err is 0 whenever sel_mem_s4=0.
- **Raw read word:** d_mem_rdata_s5 always carries the raw word; it is not affected by extension.
- **Reset mid-operation:** all stages clear immediately (asynchronous). The first capture after rst falls is a normal s4 capture.

Test Plan:
- STAGES=1, BITS=32: valid load, byte_en=4'b0100, load_signed=1, rdata=32'h1280_FF34, waddr=5 → next cycle load_data_s5=wb_data_s5=32'hFFFF_FF80, rw_s5=0, waddr_s5=5, valid_s5=1.
- Halfword loads: byte_en=4'b1100, signed=0, rdata=32'h8001_0000 → load_data_s5=32'h0000_8001. Then byte_en=4'b0110 → load_data_s5=32'h8001_0000, lane_err_s5=1.
- STAGES=3: three back-to-back ALU ops A,B,C with stall pulsed 2 cycles after B enters → A,B,C emerge in order at s5, latency 3 plus 2 hold cycles, no duplicates or drops.
- Flush and stall:
  - flush=1 with valid rw_s4=0 → s5 bubble: valid_s5=0, rw_s5=1, link_rw_s5=1.
  - flush=1 with stall=1 → outputs unchanged.
- Halt: valid halt followed by writes → halt_s5=1, stays high. Later writes never appear (rw_s5 stays at the halt entry's value). rst pulse → halt_s5=0, byte_en_s5=4'hF, rw_s5=1.
- Asynchronous reset: rst asserted between clock edges mid-stream → all outputs take reset values before the next edge.

Source files
------------

// File: rtl/pipe_mem_wb_ext_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_wb_ext_if
// Brief    : s4 -> s5 MEM/WB bus bundle; s4 side driven by the core, s5 side by the register.
// Revision : 1.0
// ============================================================================
interface pipe_mem_wb_ext_if #(
  parameter int BITS      = 32,
  parameter int ADDR_LEFT = 4,
  parameter int BE_W      = BITS / 8
);
  logic                 stall;
  logic                 flush;
  logic                 valid_s4;
  logic [BITS-1:0]      alu_out_s4;
  logic                 atomic_s4;
  logic                 link_rw_s4;
  logic [BITS-1:0]      d_mem_rdata;
  logic                 sel_mem_s4;
  logic                 rw_s4;
  logic [ADDR_LEFT:0]   waddr_s4;
  logic [BE_W-1:0]      byte_en_s4;
  logic                 load_signed_s4;
  logic                 halt_s4;

  logic                 valid_s5;
  logic [BITS-1:0]      alu_out_s5;
  logic                 atomic_s5;
  logic                 sel_mem_s5;
  logic [BITS-1:0]      d_mem_rdata_s5;
  logic [BITS-1:0]      load_data_s5;
  logic [BITS-1:0]      wb_data_s5;
  logic                 link_rw_s5;
  logic                 rw_s5;
  logic [ADDR_LEFT:0]   waddr_s5;
  logic [BE_W-1:0]      byte_en_s5;
  logic                 lane_err_s5;
  logic                 halt_s5;

  modport master (
    output stall, flush, valid_s4, alu_out_s4, atomic_s4, link_rw_s4, d_mem_rdata,
           sel_mem_s4, rw_s4, waddr_s4, byte_en_s4, load_signed_s4, halt_s4,
    input  valid_s5, alu_out_s5, atomic_s5, sel_mem_s5, d_mem_rdata_s5, load_data_s5,
           wb_data_s5, link_rw_s5, rw_s5, waddr_s5, byte_en_s5, lane_err_s5, halt_s5
  );

  modport slave (
    input  stall, flush, valid_s4, alu_out_s4, atomic_s4, link_rw_s4, d_mem_rdata,
           sel_mem_s4, rw_s4, waddr_s4, byte_en_s4, load_signed_s4, halt_s4,
    output valid_s5, alu_out_s5, atomic_s5, sel_mem_s5, d_mem_rdata_s5, load_data_s5,
           wb_data_s5, link_rw_s5, rw_s5, waddr_s5, byte_en_s5, lane_err_s5, halt_s5
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mem_wb_ext.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_wb_ext
// Brief    : Multi-stage MEM/WB register with load alignment, bubbles and sticky halt.
// Revision : 1.0
// ============================================================================
module pipe_mem_wb_ext #(
  parameter int BITS      = 32,
  parameter int REG_WORDS = 32,
  parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
  parameter int STAGES    = 1,
  parameter int BE_W      = BITS / 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pipe_mem_wb_ext_if.slave bus
);

  if ((BITS % 8 != 0) || (BITS < 16) || (STAGES < 1) || (STAGES > 4) ||
      ((1 << (ADDR_LEFT + 1)) < REG_WORDS)) begin : g_param_check
    $error("pipe_mem_wb_ext: illegal parameter combination");
  end

  typedef struct packed {
    logic               valid;
    logic [BITS-1:0]    alu;
    logic               atomic;
    logic               link_rw;
    logic [BITS-1:0]    rdata;
    logic [BITS-1:0]    load;
    logic               sel_mem;
    logic               rw;
    logic [ADDR_LEFT:0] waddr;
    logic [BE_W-1:0]    be;
    logic               lane_err;
    logic               halt;
  } stage_t;

  stage_t          w_bubble;
  stage_t          w_cap;
  stage_t          w_chain [STAGES+1];
  logic            w_freeze;
  logic            w_adv;

  logic [BE_W-1:0]   w_byte_hit;
  logic [BE_W/2-1:0] w_half_hit;
  logic [BITS-1:0]   w_byte_acc [BE_W+1];
  logic [BITS-1:0]   w_half_acc [BE_W/2+1];
  logic              w_all_lanes;
  logic              w_legal;
  logic [BITS-1:0]   w_load;

  // Each legal lane pattern contributes its extended value; at most one hits.
  assign w_byte_acc[0] = '0;
  assign w_half_acc[0] = '0;

  for (genvar k = 0; k < BE_W; k++) begin : g_lane
    logic [7:0]      w_b;
    logic [BITS-1:0] w_bx;
    assign w_b             = bus.d_mem_rdata[8*k +: 8];
    assign w_bx            = bus.load_signed_s4 ? BITS'($signed(w_b)) : BITS'(w_b);
    assign w_byte_hit[k]   = (bus.byte_en_s4 == BE_W'(1 << k));
    assign w_byte_acc[k+1] = w_byte_acc[k] | (w_byte_hit[k] ? w_bx : '0);
  end

  for (genvar j = 0; j < BE_W / 2; j++) begin : g_half
    logic [15:0]     w_h;
    logic [BITS-1:0] w_hx;
    assign w_h             = bus.d_mem_rdata[16*j +: 16];
    assign w_hx            = bus.load_signed_s4 ? BITS'($signed(w_h)) : BITS'(w_h);
    assign w_half_hit[j]   = (bus.byte_en_s4 == BE_W'(3 << (2 * j)));
    assign w_half_acc[j+1] = w_half_acc[j] | (w_half_hit[j] ? w_hx : '0);
  end

  assign w_all_lanes = &bus.byte_en_s4;
  assign w_legal     = w_all_lanes | (|w_byte_hit) | (|w_half_hit);

  always_comb begin
    w_load = bus.d_mem_rdata;
    if (!w_all_lanes) begin
      if (|w_byte_hit)      w_load = w_byte_acc[BE_W];
      else if (|w_half_hit) w_load = w_half_acc[BE_W/2];
    end
  end

  always_comb begin
    w_bubble         = '0;
    w_bubble.link_rw = 1'b1;
    w_bubble.rw      = 1'b1;
    w_bubble.be      = '1;
  end

  always_comb begin
    w_cap = w_bubble;
    if (bus.valid_s4 && !bus.flush) begin
      w_cap.valid    = 1'b1;
      w_cap.alu      = bus.alu_out_s4;
      w_cap.atomic   = bus.atomic_s4;
      w_cap.link_rw  = bus.link_rw_s4;
      w_cap.rdata    = bus.d_mem_rdata;
      w_cap.load     = w_load;
      w_cap.sel_mem  = bus.sel_mem_s4;
      w_cap.rw       = bus.rw_s4;
      w_cap.waddr    = bus.waddr_s4;
      w_cap.be       = bus.byte_en_s4;
      w_cap.lane_err = bus.sel_mem_s4 & ~w_legal;
      w_cap.halt     = bus.halt_s4;
    end
  end

  // A valid halt parked in the last stage blocks all further advancement.
  assign w_freeze   = w_chain[STAGES].valid & w_chain[STAGES].halt;
  assign w_adv      = ~bus.stall & ~w_freeze;
  assign w_chain[0] = w_cap;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t r_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= w_bubble;
      end else if (w_adv) begin
        r_q <= w_chain[s];
      end
    end
    assign w_chain[s+1] = r_q;
  end

  assign bus.valid_s5       = w_chain[STAGES].valid;
  assign bus.alu_out_s5     = w_chain[STAGES].alu;
  assign bus.atomic_s5      = w_chain[STAGES].atomic;
  assign bus.sel_mem_s5     = w_chain[STAGES].sel_mem;
  assign bus.d_mem_rdata_s5 = w_chain[STAGES].rdata;
  assign bus.load_data_s5   = w_chain[STAGES].load;
  assign bus.wb_data_s5     = w_chain[STAGES].sel_mem ? w_chain[STAGES].load : w_chain[STAGES].alu;
  assign bus.link_rw_s5     = w_chain[STAGES].link_rw;
  assign bus.rw_s5          = w_chain[STAGES].rw;
  assign bus.waddr_s5       = w_chain[STAGES].waddr;
  assign bus.byte_en_s5     = w_chain[STAGES].be;
  assign bus.lane_err_s5    = w_chain[STAGES].lane_err;
  assign bus.halt_s5        = w_freeze;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_wb_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mem_wb_ext
// Brief    : Bench driving STAGES=1 and STAGES=3 instances from one s4 stream.
// Revision : 1.0
// ============================================================================
module tb_pipe_mem_wb_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        d_stall = 0, d_flush = 0, d_valid = 0, d_atomic = 0, d_link_rw = 1;
  logic        d_sel_mem = 0, d_rw = 1, d_lsigned = 0, d_halt = 0;
  logic [31:0] d_alu = 0, d_rdata = 0;
  logic [4:0]  d_waddr = 0;
  logic [3:0]  d_be = 4'hF;

  pipe_mem_wb_ext_if #(.BITS(32), .ADDR_LEFT(4), .BE_W(4)) bus1 ();
  pipe_mem_wb_ext_if #(.BITS(32), .ADDR_LEFT(4), .BE_W(4)) bus3 ();

  assign bus1.stall = d_stall;             assign bus3.stall = d_stall;
  assign bus1.flush = d_flush;             assign bus3.flush = d_flush;
  assign bus1.valid_s4 = d_valid;          assign bus3.valid_s4 = d_valid;
  assign bus1.alu_out_s4 = d_alu;          assign bus3.alu_out_s4 = d_alu;
  assign bus1.atomic_s4 = d_atomic;        assign bus3.atomic_s4 = d_atomic;
  assign bus1.link_rw_s4 = d_link_rw;      assign bus3.link_rw_s4 = d_link_rw;
  assign bus1.d_mem_rdata = d_rdata;       assign bus3.d_mem_rdata = d_rdata;
  assign bus1.sel_mem_s4 = d_sel_mem;      assign bus3.sel_mem_s4 = d_sel_mem;
  assign bus1.rw_s4 = d_rw;                assign bus3.rw_s4 = d_rw;
  assign bus1.waddr_s4 = d_waddr;          assign bus3.waddr_s4 = d_waddr;
  assign bus1.byte_en_s4 = d_be;           assign bus3.byte_en_s4 = d_be;
  assign bus1.load_signed_s4 = d_lsigned;  assign bus3.load_signed_s4 = d_lsigned;
  assign bus1.halt_s4 = d_halt;            assign bus3.halt_s4 = d_halt;

  pipe_mem_wb_ext #(.BITS(32), .REG_WORDS(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  pipe_mem_wb_ext #(.BITS(32), .REG_WORDS(32), .STAGES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  typedef struct packed {
    logic valid; logic [31:0] alu; logic atomic; logic link_rw;
    logic [31:0] rdata; logic [31:0] load; logic sel_mem; logic rw;
    logic [4:0] waddr; logic [3:0] be; logic lane_err; logic halt; logic [31:0] wb;
  } ent_t;

  function automatic ent_t rst_ent();
    ent_t e = '0;
    e.link_rw = 1'b1; e.rw = 1'b1; e.be = 4'hF;
    return e;
  endfunction

  // Reference: what an s4 instruction should look like once it reaches writeback.
  function automatic ent_t capture();
    ent_t e;
    logic [31:0] v;
    bit legal;
    if (d_flush || !d_valid) return rst_ent();
    e.valid = 1; e.alu = d_alu; e.atomic = d_atomic; e.link_rw = d_link_rw;
    e.rdata = d_rdata; e.sel_mem = d_sel_mem; e.rw = d_rw; e.waddr = d_waddr;
    e.be = d_be; e.halt = d_halt; e.load = d_rdata; legal = 0;
    if (d_be == 4'hF) legal = 1;
    else if ($countones(d_be) == 1) begin
      for (int k = 0; k < 4; k++)
        if (d_be[k]) begin
          v = (d_rdata >> (8 * k)) & 32'hFF;
          if (d_lsigned && v[7]) v = v | 32'hFFFF_FF00;
          e.load = v;
        end
      legal = 1;
    end else if (d_be == 4'b0011 || d_be == 4'b1100) begin
      v = d_be[0] ? (d_rdata & 32'hFFFF) : (d_rdata >> 16);
      if (d_lsigned && v[15]) v = v | 32'hFFFF_0000;
      e.load = v;
      legal = 1;
    end
    e.lane_err = d_sel_mem && !legal;
    e.wb = e.sel_mem ? e.load : e.alu;
    return e;
  endfunction

  ent_t h1[$];
  ent_t h3[$];
  bit   fz1 = 0, fz3 = 0;

  function automatic ent_t exp1();
    if (h1.size() >= 1) return h1[h1.size() - 1];
    return rst_ent();
  endfunction

  function automatic ent_t exp3();
    if (h3.size() >= 3) return h3[h3.size() - 3];
    return rst_ent();
  endfunction

  always @(posedge clk or posedge rst) begin
    ent_t c, x;
    if (rst) begin
      h1.delete(); h3.delete(); fz1 = 0; fz3 = 0;
    end else begin
      c = capture();
      if (!d_stall && !fz1) h1.push_back(c);
      if (!d_stall && !fz3) h3.push_back(c);
      if (h1.size() > 8) void'(h1.pop_front());
      if (h3.size() > 8) void'(h3.pop_front());
      x = exp1(); if (x.valid && x.halt) fz1 = 1;
      x = exp3(); if (x.valid && x.halt) fz3 = 1;
    end
  end

  function automatic ent_t act1();
    ent_t a;
    a.valid = bus1.valid_s5; a.alu = bus1.alu_out_s5; a.atomic = bus1.atomic_s5;
    a.link_rw = bus1.link_rw_s5; a.rdata = bus1.d_mem_rdata_s5; a.load = bus1.load_data_s5;
    a.sel_mem = bus1.sel_mem_s5; a.rw = bus1.rw_s5; a.waddr = bus1.waddr_s5;
    a.be = bus1.byte_en_s5; a.lane_err = bus1.lane_err_s5; a.halt = bus1.halt_s5;
    a.wb = bus1.wb_data_s5;
    return a;
  endfunction

  function automatic ent_t act3();
    ent_t a;
    a.valid = bus3.valid_s5; a.alu = bus3.alu_out_s5; a.atomic = bus3.atomic_s5;
    a.link_rw = bus3.link_rw_s5; a.rdata = bus3.d_mem_rdata_s5; a.load = bus3.load_data_s5;
    a.sel_mem = bus3.sel_mem_s5; a.rw = bus3.rw_s5; a.waddr = bus3.waddr_s5;
    a.be = bus3.byte_en_s5; a.lane_err = bus3.lane_err_s5; a.halt = bus3.halt_s5;
    a.wb = bus3.wb_data_s5;
    return a;
  endfunction

  task automatic drv(input logic v, input logic st, input logic fl, input logic sm,
                     input logic rw, input logic sg, input logic hl,
                     input logic [31:0] alu, input logic [31:0] rd,
                     input logic [4:0] wa, input logic [3:0] be);
    d_valid = v; d_stall = st; d_flush = fl; d_sel_mem = sm; d_rw = rw; d_lsigned = sg;
    d_halt = hl; d_alu = alu; d_rdata = rd; d_waddr = wa; d_be = be;
    d_atomic = 0; d_link_rw = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ent_t a;
    repeat (2) @(posedge clk);
    #1;
    a = act1(); total++;
    if (a !== rst_ent()) begin bad++; $display("FAIL reset_s1 actual=%h required=%h", a, rst_ent()); end
    a = act3(); total++;
    if (a !== rst_ent()) begin bad++; $display("FAIL reset_s3 actual=%h required=%h", a, rst_ent()); end
    rst = 1'b0;
  endtask

  task automatic test_byte_load();
    ent_t a, e;
    drv(1, 0, 0, 1, 0, 1, 0, 32'h0000_1002, 32'h1280_FF34, 5'd5, 4'b0100);
    tick();
    a = act1(); e = exp1(); total++;
    if (a !== e) begin bad++; $display("FAIL byte_load_model actual=%h required=%h", a, e); end
    total++;
    if ({a.load, a.wb, a.rw, a.waddr, a.valid} !== {32'hFFFF_FF80, 32'hFFFF_FF80, 1'b0, 5'd5, 1'b1}) begin
      bad++; $display("FAIL byte_load_fields actual=%h/%h/%b/%0d/%b required=ffffff80/ffffff80/0/5/1",
                      a.load, a.wb, a.rw, a.waddr, a.valid);
    end
  endtask

  task automatic test_halfword();
    ent_t a, e;
    drv(1, 0, 0, 1, 0, 0, 0, 32'h0000_2000, 32'h8001_0000, 5'd6, 4'b1100);
    tick();
    a = act1(); e = exp1(); total++;
    if (a !== e) begin bad++; $display("FAIL half_hi_model actual=%h required=%h", a, e); end
    total++;
    if ({a.load, a.lane_err} !== {32'h0000_8001, 1'b0}) begin
      bad++; $display("FAIL half_hi actual=%h err=%b required=00008001 err=0", a.load, a.lane_err);
    end
    drv(1, 0, 0, 1, 0, 0, 0, 32'h0000_2004, 32'h8001_0000, 5'd6, 4'b0110);
    tick();
    a = act1(); e = exp1(); total++;
    if (a !== e) begin bad++; $display("FAIL half_odd_model actual=%h required=%h", a, e); end
    total++;
    if ({a.load, a.lane_err} !== {32'h8001_0000, 1'b1}) begin
      bad++; $display("FAIL half_odd actual=%h err=%b required=80010000 err=1", a.load, a.lane_err);
    end
  endtask

  task automatic test_back_to_back();
    ent_t a, e;
    logic [31:0] want [8];
    want = '{0, 0, 0, 32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int c = 1; c <= 7; c++) begin
      case (c)
        1: drv(1, 0, 0, 0, 0, 0, 0, 32'hAAAA_0001, 32'h0, 5'd1, 4'hF);
        2: drv(1, 0, 0, 0, 0, 0, 0, 32'hBBBB_0002, 32'h0, 5'd2, 4'hF);
        3: drv(1, 0, 0, 0, 0, 0, 0, 32'hCCCC_0003, 32'h0, 5'd3, 4'hF);
        4, 5: drv(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 5'd0, 4'hF);
        default: drv(0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 5'd0, 4'hF);
      endcase
      tick();
      a = act3(); e = exp3(); total++;
      if (a !== e) begin bad++; $display("FAIL b2b_model cyc=%0d actual=%h required=%h", c, a, e); end
      if (c >= 3) begin
        total++;
        if ({a.valid, a.alu} !== {1'b1, want[c]}) begin
          bad++; $display("FAIL b2b_order cyc=%0d actual=%b/%h required=1/%h", c, a.valid, a.alu, want[c]);
        end
      end
    end
  endtask

  task automatic test_flush();
    ent_t a, e;
    drv(1, 0, 1, 0, 0, 0, 0, 32'h1234_5678, 32'h0, 5'd9, 4'hF);
    tick();
    a = act1(); e = exp1(); total++;
    if ({a.valid, a.rw, a.link_rw} !== 3'b011 || a !== e) begin
      bad++; $display("FAIL flush_bubble actual=%h required=%h", a, e);
    end
    drv(1, 0, 0, 0, 0, 0, 0, 32'h5555_AAAA, 32'h0, 5'd10, 4'hF);
    tick();
    drv(1, 1, 1, 0, 0, 0, 0, 32'h7777_7777, 32'h0, 5'd11, 4'hF);
    tick();
    a = act1(); e = exp1(); total++;
    if ({a.valid, a.alu, a.waddr} !== {1'b1, 32'h5555_AAAA, 5'd10} || a !== e) begin
      bad++; $display("FAIL flush_stall actual=%h required=%h", a, e);
    end
  endtask

  task automatic test_random();
    ent_t a, e;
    for (int i = 0; i < 400; i++) begin
      d_stall = ($urandom_range(0, 4) == 0); d_flush = ($urandom_range(0, 9) == 0);
      d_valid = ($urandom_range(0, 9) < 7);  d_alu = $urandom; d_rdata = $urandom;
      d_atomic = $urandom_range(0, 1); d_link_rw = $urandom_range(0, 1);
      d_sel_mem = $urandom_range(0, 1); d_rw = $urandom_range(0, 1);
      d_lsigned = $urandom_range(0, 1); d_waddr = 5'($urandom); d_be = 4'($urandom);
      d_halt = 0;
      tick();
      a = act1(); e = exp1(); total++;
      if (a !== e) begin bad++; $display("FAIL rand_s1 i=%0d actual=%h required=%h", i, a, e); end
      a = act3(); e = exp3(); total++;
      if (a !== e) begin bad++; $display("FAIL rand_s3 i=%0d actual=%h required=%h", i, a, e); end
    end
  endtask

  task automatic test_halt();
    ent_t a, e;
    drv(1, 0, 0, 0, 0, 0, 1, 32'hDEAD_0007, 32'h0, 5'd7, 4'hF);
    tick();
    for (int i = 0; i < 6; i++) begin
      drv(1, 0, 0, 0, 0, 0, 0, 32'h0BAD_0000 + i, 32'h0, 5'd9, 4'hF);
      a = act1(); total++;
      if ({a.halt, a.rw, a.waddr, a.alu} !== {1'b1, 1'b0, 5'd7, 32'hDEAD_0007}) begin
        bad++; $display("FAIL halt_hold i=%0d actual=%b/%b/%0d/%h required=1/0/7/dead0007",
                        i, a.halt, a.rw, a.waddr, a.alu);
      end
      a = act3(); e = exp3(); total++;
      if (a !== e) begin bad++; $display("FAIL halt_s3 i=%0d actual=%h required=%h", i, a, e); end
      tick();
    end
    a = act3(); total++;
    if ({a.halt, a.waddr} !== {1'b1, 5'd7}) begin
      bad++; $display("FAIL halt_s3_final actual=%b/%0d required=1/7", a.halt, a.waddr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    a = act1(); total++;
    if ({a.halt, a.be, a.rw} !== {1'b0, 4'hF, 1'b1}) begin
      bad++; $display("FAIL halt_reset actual=%b/%h/%b required=0/f/1", a.halt, a.be, a.rw);
    end
    a = act3(); total++;
    if (a !== rst_ent()) begin bad++; $display("FAIL halt_reset_s3 actual=%h required=%h", a, rst_ent()); end
    #1 rst = 1'b0;
  endtask

  task automatic test_async_reset();
    ent_t a, e;
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 1, 0, 1, 0, $urandom, $urandom, 5'(i + 1), 4'b0001);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    a = act1(); total++;
    if (a !== rst_ent()) begin bad++; $display("FAIL async_rst_s1 actual=%h required=%h", a, rst_ent()); end
    a = act3(); total++;
    if (a !== rst_ent()) begin bad++; $display("FAIL async_rst_s3 actual=%h required=%h", a, rst_ent()); end
    #1 rst = 1'b0;
    drv(1, 0, 0, 1, 0, 0, 0, 32'h4444_0000, 32'hCAFE_F00D, 5'd12, 4'b0011);
    tick();
    a = act1(); e = exp1(); total++;
    if (a !== e || a.load !== 32'h0000_F00D) begin
      bad++; $display("FAIL post_rst_capture actual=%h required=%h", a, e);
    end
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_halfword();
    test_back_to_back();
    test_flush();
    test_random();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
